// File: rtl/rx_comando_ctrl.sv
// rx_comando_ctrl: assembles '#'...';' frames from the 7E1 receiver's
// character stream into a small buffer and hands each complete command to
// the consumer through a level-held cmd_pronto / cmd_ack handshake.
// Parity errors, overlong frames and inter-character timeouts are rejected
// and the number of discarded frames is tracked in a saturating counter.
module rx_comando_ctrl #(
    parameter int AW      = 3,
    parameter int TIMEOUT = 43400,
    parameter int TW      = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rx_pronto,
    input  logic [6:0]    rx_dados,
    input  logic          rx_erro,
    input  logic          cmd_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [6:0]    rd_data,
    output logic          cmd_pronto,
    output logic [AW:0]   cmd_len,
    output logic          erro_quadro,
    output logic [7:0]    cnt_descartes,
    output logic [3:0]    db_estado
);

    localparam int          MAX_LEN    = 2 ** AW;
    localparam logic [AW:0] LEN_CHEIO  = (AW + 1)'(MAX_LEN);
    localparam logic [TW-1:0] TIMER_FIM = TW'(TIMEOUT - 1);
    localparam logic [6:0]  CHR_INICIO = 7'h23;  // '#'
    localparam logic [6:0]  CHR_FIM    = 7'h3B;  // ';'

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        RECEBE   = 2'd1,
        PRONTO   = 2'd2,
        DESCARTA = 2'd3
    } estado_t;

    estado_t       estado;
    logic [AW:0]   comp;              // payload characters stored so far
    logic [TW-1:0] timer;             // cycles since the last character
    logic [6:0]    mem [MAX_LEN];

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Buffer read port is purely combinational; addresses past cmd_len show stale data.
    assign rd_data   = mem[rd_addr];
    assign db_estado = {2'b00, estado};

    // Frame sequencer: state, buffer, timer and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= ESPERA;
            comp          <= '0;
            timer         <= '0;
            cmd_pronto    <= 1'b0;
            cmd_len       <= '0;
            erro_quadro   <= 1'b0;
            cnt_descartes <= '0;
            // NOTE: the buffer is small and must read back as zero after reset,
            // so it is built from flops and cleared here rather than left as RAM.
            for (int i = 0; i < MAX_LEN; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: every register here uses <= so all branches see pre-edge values.
            erro_quadro <= 1'b0;
            case (estado)
                ESPERA: begin
                    timer <= '0;
                    if (rx_pronto && !rx_erro && rx_dados == CHR_INICIO) begin
                        estado <= RECEBE;
                        comp   <= '0;
                    end
                end

                RECEBE: begin
                    if (rx_pronto) begin
                        timer <= '0;
                        if (rx_erro) begin
                            estado        <= DESCARTA;
                            erro_quadro   <= 1'b1;
                            cnt_descartes <= sat_inc(cnt_descartes);
                        end else if (rx_dados == CHR_INICIO) begin
                            comp <= '0;
                        end else if (rx_dados == CHR_FIM) begin
                            if (comp == '0) begin
                                estado <= ESPERA;
                            end else begin
                                estado     <= PRONTO;
                                cmd_pronto <= 1'b1;
                                cmd_len    <= comp;
                            end
                        end else if (comp == LEN_CHEIO) begin
                            estado        <= DESCARTA;
                            erro_quadro   <= 1'b1;
                            cnt_descartes <= sat_inc(cnt_descartes);
                        end else begin
                            mem[comp[AW-1:0]] <= rx_dados;
                            comp              <= comp + 1'b1;
                        end
                    end else if (timer == TIMER_FIM) begin
                        estado        <= ESPERA;
                        timer         <= '0;
                        erro_quadro   <= 1'b1;
                        cnt_descartes <= sat_inc(cnt_descartes);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                PRONTO: begin
                    timer <= '0;
                    // A new frame start while a command is held is lost but counted.
                    if (rx_pronto && rx_dados == CHR_INICIO) begin
                        cnt_descartes <= sat_inc(cnt_descartes);
                    end
                    if (cmd_ack) begin
                        estado     <= ESPERA;
                        cmd_pronto <= 1'b0;
                    end
                end

                DESCARTA: begin
                    if (rx_pronto) begin
                        timer <= '0;
                        if (rx_dados == CHR_FIM) begin
                            estado <= ESPERA;
                        end else if (rx_dados == CHR_INICIO && !rx_erro) begin
                            estado <= RECEBE;
                            comp   <= '0;
                        end
                    end else if (timer == TIMER_FIM) begin
                        estado <= ESPERA;
                        timer  <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: estado <= ESPERA;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_comando_ctrl.sv
// Self-checking bench for rx_comando_ctrl: expected commands are queued as
// frames are sent and popped when cmd_pronto rises.
module tb_rx_comando_ctrl;

    localparam int AW      = 3;
    localparam int TIMEOUT = 20;
    localparam int TW      = 8;
    localparam int MAX_LEN = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          rx_pronto;
    logic [6:0]    rx_dados;
    logic          rx_erro;
    logic          cmd_ack;
    logic [AW-1:0] rd_addr;
    logic [6:0]    rd_data;
    logic          cmd_pronto;
    logic [AW:0]   cmd_len;
    logic          erro_quadro;
    logic [7:0]    cnt_descartes;
    logic [3:0]    db_estado;

    int    n_vec   = 0;
    int    n_err   = 0;
    int    n_pulsos = 0;
    string exp_q[$];

    rx_comando_ctrl #(.AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clock(clock), .reset(reset), .rx_pronto(rx_pronto), .rx_dados(rx_dados),
        .rx_erro(rx_erro), .cmd_ack(cmd_ack), .rd_addr(rd_addr), .rd_data(rd_data),
        .cmd_pronto(cmd_pronto), .cmd_len(cmd_len), .erro_quadro(erro_quadro),
        .cnt_descartes(cnt_descartes), .db_estado(db_estado)
    );

    always #10 clock = ~clock;

    // Count every reject pulse, sampled mid-cycle.
    always @(negedge clock) if (erro_quadro === 1'b1) n_pulsos++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [6:0] c, input logic e);
        rx_pronto = 1'b1; rx_dados = c; rx_erro = e;
        tick();
        rx_pronto = 1'b0; rx_erro = 1'b0;
    endtask

    task automatic send_str(input string s);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send(b[6:0], 1'b0);
        end
    endtask

    // Wait (bounded) for a held command, compare it with the queue head, optionally ack.
    task automatic check_cmd(input bit do_ack);
        string    exp;
        byte      b;
        int       k;
        logic [3:0] ln;
        k = 0;
        for (int i = 0; i < 20 && cmd_pronto !== 1'b1; i++) begin tick(); k++; end
        n_vec++;
        if (cmd_pronto !== 1'b1) begin n_err++; $display("FAIL cmd_wait: cmd_pronto=%b after %0d cycles, required 1", cmd_pronto, k); return; end
        if (exp_q.size() == 0) begin n_err++; n_vec++; $display("FAIL cmd_unexpected: command len %0d with empty scoreboard", cmd_len); return; end
        exp = exp_q.pop_front();
        ln  = 4'(exp.len());
        n_vec++;
        if (cmd_len !== ln) begin n_err++; $display("FAIL cmd_len: got %0d required %0d", cmd_len, ln); end
        for (int i = 0; i < exp.len(); i++) begin
            b = exp[i];
            rd_addr = AW'(i);
            #1;
            n_vec++;
            if (rd_data !== b[6:0]) begin n_err++; $display("FAIL cmd_data[%0d]: got %h required %h", i, rd_data, b[6:0]); end
        end
        if (do_ack) begin
            cmd_ack = 1'b1;
            tick();
            cmd_ack = 1'b0;
            n_vec++;
            if (cmd_pronto !== 1'b0 || db_estado !== 4'd0) begin n_err++; $display("FAIL ack: cmd_pronto=%b estado=%0d required 0/0", cmd_pronto, db_estado); end
            n_vec++;
            if (cmd_len !== ln) begin n_err++; $display("FAIL len_hold: got %0d required %0d", cmd_len, ln); end
        end
    endtask

    task automatic measure_timeout(output int k);
        k = 0;
        for (int i = 1; i <= TIMEOUT + 5; i++) begin
            tick();
            if (erro_quadro === 1'b1) begin k = i; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        n_vec++;
        if (cmd_pronto !== 1'b0 || cmd_len !== '0 || erro_quadro !== 1'b0) begin n_err++; $display("FAIL reset_out: pronto=%b len=%0d erro=%b required 0", cmd_pronto, cmd_len, erro_quadro); end
        n_vec++;
        if (cnt_descartes !== 8'd0 || db_estado !== 4'd0) begin n_err++; $display("FAIL reset_cnt: cnt=%0d estado=%0d required 0/0", cnt_descartes, db_estado); end
        for (int i = 0; i < MAX_LEN; i++) begin
            rd_addr = AW'(i);
            #1;
            n_vec++;
            if (rd_data !== 7'd0) begin n_err++; $display("FAIL reset_buf[%0d]: got %h required 00", i, rd_data); end
        end
    endtask

    task automatic test_basic();
        send_str("#AB");
        send(7'h43, 1'b0);
        n_vec++;
        if (cmd_pronto !== 1'b0 || db_estado !== 4'd1) begin n_err++; $display("FAIL basic_early: pronto=%b estado=%0d required 0/1", cmd_pronto, db_estado); end
        exp_q.push_back("ABC");
        send(7'h3B, 1'b0);
        n_vec++;
        if (cmd_pronto !== 1'b1 || db_estado !== 4'd2) begin n_err++; $display("FAIL basic_latency: pronto=%b estado=%0d required 1/2", cmd_pronto, db_estado); end
        check_cmd(1'b1);
    endtask

    task automatic test_parity();
        int p0;
        p0 = n_pulsos;
        send_str("#X");
        send(7'h59, 1'b1);
        n_vec++;
        if (erro_quadro !== 1'b1 || cnt_descartes !== 8'd1 || db_estado !== 4'd3) begin n_err++; $display("FAIL parity_reject: erro=%b cnt=%0d estado=%0d required 1/1/3", erro_quadro, cnt_descartes, db_estado); end
        send_str("Z;");
        tick();
        n_vec++;
        if (cmd_pronto !== 1'b0 || db_estado !== 4'd0 || n_pulsos !== p0 + 1) begin n_err++; $display("FAIL parity_end: pronto=%b estado=%0d pulses=%0d required 0/0/%0d", cmd_pronto, db_estado, n_pulsos - p0, 1); end
    endtask

    task automatic test_overflow();
        logic [7:0] c0;
        c0 = cnt_descartes;
        send_str("#12345678");
        n_vec++;
        if (db_estado !== 4'd1 || cnt_descartes !== c0) begin n_err++; $display("FAIL ovf_full: estado=%0d cnt=%0d required 1/%0d", db_estado, cnt_descartes, c0); end
        send(7'h39, 1'b0);
        n_vec++;
        if (erro_quadro !== 1'b1 || db_estado !== 4'd3 || cnt_descartes !== c0 + 8'd1) begin n_err++; $display("FAIL ovf_reject: erro=%b estado=%0d cnt=%0d required 1/3/%0d", erro_quadro, db_estado, cnt_descartes, c0 + 8'd1); end
        exp_q.push_back("Q");
        send_str("#Q;");
        check_cmd(1'b0);
        rd_addr = 3'd1;
        #1;
        n_vec++;
        if (rd_data !== 7'h32) begin n_err++; $display("FAIL ovf_stale: got %h required 32", rd_data); end
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
    endtask

    task automatic test_timeout();
        int k;
        logic [7:0] c0;
        int p0;
        c0 = cnt_descartes;
        send_str("#A");
        measure_timeout(k);
        n_vec++;
        if (k !== TIMEOUT) begin n_err++; $display("FAIL timeout_delay: got %0d required %0d", k, TIMEOUT); end
        n_vec++;
        if (db_estado !== 4'd0 || cnt_descartes !== c0 + 8'd1) begin n_err++; $display("FAIL timeout_state: estado=%0d cnt=%0d required 0/%0d", db_estado, cnt_descartes, c0 + 8'd1); end
        // A character part-way through restarts the timeout window.
        send_str("#A");
        idle(TIMEOUT - 3);
        send_str("B");
        measure_timeout(k);
        n_vec++;
        if (k !== TIMEOUT) begin n_err++; $display("FAIL timeout_restart: got %0d required %0d", k, TIMEOUT); end
        tick();
        p0 = n_pulsos;
        c0 = cnt_descartes;
        send_str("#;");
        tick();
        n_vec++;
        if (db_estado !== 4'd0 || cnt_descartes !== c0 || n_pulsos !== p0) begin n_err++; $display("FAIL empty_frame: estado=%0d cnt=%0d pulses=%0d required 0/%0d/0", db_estado, cnt_descartes, n_pulsos - p0, c0); end
        // Timeout while discarding returns to ESPERA with no extra reject.
        send_str("#");
        send(7'h65, 1'b1);
        idle(TIMEOUT + 2);
        n_vec++;
        if (db_estado !== 4'd0 || cnt_descartes !== c0 + 8'd1 || n_pulsos !== p0 + 1) begin n_err++; $display("FAIL discard_timeout: estado=%0d cnt=%0d pulses=%0d required 0/%0d/1", db_estado, cnt_descartes, n_pulsos - p0, c0 + 8'd1); end
    endtask

    task automatic test_pronto_hash();
        logic [7:0] c0;
        exp_q.push_back("MN");
        send_str("#MN;");
        check_cmd(1'b0);
        c0 = cnt_descartes;
        send_str("#K;");
        rd_addr = 3'd0;
        #1;
        n_vec++;
        if (cnt_descartes !== c0 + 8'd1 || cmd_len !== 4'd2 || rd_data !== 7'h4D || cmd_pronto !== 1'b1) begin n_err++; $display("FAIL pronto_hash: cnt=%0d len=%0d d0=%h pronto=%b required %0d/2/4d/1", cnt_descartes, cmd_len, rd_data, cmd_pronto, c0 + 8'd1); end
        send(7'h23, 1'b1);
        n_vec++;
        if (cnt_descartes !== c0 + 8'd2 || erro_quadro !== 1'b0) begin n_err++; $display("FAIL pronto_hash_err: cnt=%0d erro=%b required %0d/0", cnt_descartes, erro_quadro, c0 + 8'd2); end
        cmd_ack = 1'b1;
        send(7'h23, 1'b0);
        cmd_ack = 1'b0;
        n_vec++;
        if (db_estado !== 4'd0 || cmd_pronto !== 1'b0 || cnt_descartes !== c0 + 8'd3 || cmd_len !== 4'd2) begin n_err++; $display("FAIL ack_and_hash: estado=%0d pronto=%b cnt=%0d len=%0d required 0/0/%0d/2", db_estado, cmd_pronto, cnt_descartes, c0 + 8'd3, cmd_len); end
    endtask

    task automatic test_back_to_back();
        // ack outside PRONTO is ignored; '#' mid-frame restarts the payload
        cmd_ack = 1'b1;
        send_str("#P#RS");
        cmd_ack = 1'b0;
        exp_q.push_back("RS");
        send(7'h3B, 1'b0);
        n_vec++;
        if (cmd_pronto !== 1'b1) begin n_err++; $display("FAIL ack_outside: pronto=%b required 1", cmd_pronto); end
        check_cmd(1'b1);
        exp_q.push_back("CDE");
        send_str("#CDE;");
        check_cmd(1'b1);
        exp_q.push_back("abcdefgh");
        send_str("#abcdefgh;");
        check_cmd(1'b1);
    endtask

    task automatic test_saturate();
        int p0;
        p0 = n_pulsos;
        for (int i = 0; i < 256; i++) begin
            send(7'h23, 1'b0);
            send(7'h78, 1'b1);
        end
        n_vec++;
        if (cnt_descartes !== 8'd255 || erro_quadro !== 1'b1) begin n_err++; $display("FAIL saturate: cnt=%0d erro=%b required 255/1", cnt_descartes, erro_quadro); end
        tick();
        n_vec++;
        if (n_pulsos !== p0 + 256) begin n_err++; $display("FAIL sat_pulses: got %0d required 256", n_pulsos - p0); end
        send_str("#A");
        reset = 1'b1;
        tick();
        n_vec++;
        if (cmd_pronto !== 1'b0 || cmd_len !== '0 || erro_quadro !== 1'b0 || cnt_descartes !== 8'd0 || db_estado !== 4'd0) begin n_err++; $display("FAIL mid_reset: pronto=%b len=%0d erro=%b cnt=%0d estado=%0d required all 0", cmd_pronto, cmd_len, erro_quadro, cnt_descartes, db_estado); end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; rx_pronto = 1'b0; rx_dados = '0; rx_erro = 1'b0;
        cmd_ack = 1'b0; rd_addr = '0;
        test_reset();
        test_basic();
        test_parity();
        test_overflow();
        test_timeout();
        test_pronto_hash();
        test_back_to_back();
        test_saturate();
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left: %0d commands never seen", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_comando_ctrl.md
# rx_comando_ctrl

Frame controller that sits directly behind the 7E1 serial receiver and sequences its character stream into delimited commands. It consumes the receiver's `pronto`/`dados_ascii`/parity-error outputs and assembles `#`…`;` frames into an internal character buffer. It presents each complete command to the consumer through a level-held ready/acknowledge handshake. Parity errors, overlong frames and inter-character timeouts are rejected, and discarded frames are counted.

## Interface

Parameters:
- `AW`, 3: buffer address width; buffer depth MAX_LEN = 2**AW characters.
- `TIMEOUT`, 43400: inter-character timeout in clock cycles (about 100 bit times at 115200 baud on 50 MHz).
- `TW`, 16: timer width; must satisfy 2**TW > TIMEOUT.

Ports:
- `clock`  in  1  system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_pronto`  in  1  one-cycle pulse; a received character is valid on `rx_dados`/`rx_erro`.
- `rx_dados`  in  7  received 7-bit ASCII character.
- `rx_erro`  in  1  parity error for the current character; sampled only with `rx_pronto`.
- `cmd_ack`  in  1  consumer releases the current command.
- `rd_addr`  in  AW  buffer read address.
- `rd_data`  out  7  buffer content at `rd_addr`; combinational.
- `cmd_pronto`  out  1  a complete command is held; level signal.
- `cmd_len`  out  AW+1  payload length of the held command, 1..MAX_LEN.
- `erro_quadro`  out  1  one-cycle pulse when a frame is rejected.
- `cnt_descartes`  out  8  discarded-frame counter; saturates at 255.
- `db_estado`  out  4  current state code, for the debug display.

## Operation

- Delimiters: start `#` (0x23), end `;` (0x3B). Payload is the characters between them, excluding both delimiters.
- States and codes: ESPERA=0, RECEBE=1, PRONTO=2, DESCARTA=3.
- Reset: state ESPERA. `cmd_pronto`=0, `cmd_len`=0, `erro_quadro`=0, `cnt_descartes`=0. Buffer cleared to 0, timer 0.
- ESPERA: on `rx_pronto` with `#` and `rx_erro`=0 → RECEBE; length=0, timer=0. All other characters, and any character with `rx_erro`=1, are ignored.
- RECEBE: every `rx_pronto` clears the timer. Priority on `rx_pronto`:
  - `rx_erro`=1 → DESCARTA, reject.
  - `#` → restart: length=0, stay in RECEBE, no reject.
  - `;` with length=0 → ESPERA silently; not counted.
  - `;` with length>0 → PRONTO.
  - length=MAX_LEN → DESCARTA, reject (overflow).
  - otherwise buf[length] ← char, length+1.
- RECEBE timeout: the timer increments each cycle without `rx_pronto`. When it reaches TIMEOUT−1 → ESPERA, reject.
- Reject: `erro_quadro` pulse in the transition cycle; `cnt_descartes`+1, saturating.
- DESCARTA: on `;` → ESPERA. On `#` with `rx_erro`=0 → RECEBE with length=0. Timer expiry → ESPERA with no further reject. Other characters are ignored.
- PRONTO: `cmd_pronto`=1, `cmd_len`=length; buffer and length are frozen.
  - Every `#` received, with or without error, increments `cnt_descartes`. No `erro_quadro` pulse; the character is otherwise ignored.
  - `cmd_ack`=1 → ESPERA.
- `cmd_ack` outside PRONTO has no effect.
- `rd_data`=buf[`rd_addr`] at all times. Addresses ≥ `cmd_len` return stale contents from earlier frames.
- `cmd_len` keeps its last value after ack until the next PRONTO entry; it is 0 only after reset.

## Timing

- `cmd_pronto` rises the cycle after the `rx_pronto` carrying `;`. It falls the cycle after `cmd_ack` is sampled high in PRONTO.
- The payload is readable by the time `cmd_pronto` is high: a character is written the cycle after its `rx_pronto`.
- Simultaneous `cmd_ack` and `rx_pronto`(`#`) in PRONTO: the ack is honoured and the `#` is counted and dropped; the next state is ESPERA.
- Timeout fires exactly TIMEOUT cycles after the last `rx_pronto` in RECEBE, counted from the cycle following that pulse.
- `cnt_descartes` updates in the same edge as the state transition. At 255 it holds, and `erro_quadro` still pulses.
- `reset` asserted in any state takes effect at the next edge: any held command is lost and `cmd_pronto` drops to 0.
- Throughput: accepts one character per cycle; no back-pressure toward the receiver.

## Test plan

- Frame `#`,`A`,`B`,`C`,`;` → `cmd_pronto`=1 one cycle after `;`, `cmd_len`=3, `rd_data` at addresses 0..2 = 0x41, 0x42, 0x43. Then `cmd_ack` → `cmd_pronto`=0 next cycle, `db_estado`=0.
- Frame `#`,`X`, then `Y` with `rx_erro`=1, then `Z`,`;` → one `erro_quadro` pulse, `cnt_descartes`=1, no `cmd_pronto`, final state ESPERA.
- `#` followed by 9 payload characters with MAX_LEN=8 → reject on the 9th character, `cnt_descartes`=1, state DESCARTA. A following `#Q;` gives `cmd_len`=1, `rd_data`[0]=0x51.
- `#`,`A`, then no characters for TIMEOUT cycles → `erro_quadro` pulse exactly TIMEOUT cycles after `A`, state ESPERA, count=1. Also `#;` → ESPERA with no pulse and no count.
- While PRONTO, send `#K;` → held command unchanged, `cnt_descartes`+1. `cmd_ack` asserted in the same cycle as `rx_pronto`(`#`) → ESPERA, count+1.
- 256 rejected frames → `cnt_descartes` saturates at 255. Then assert `reset` mid-RECEBE → all outputs 0, state ESPERA the next cycle.
